// File: rtl/conv1d_sequencer_if.sv
// Memory-controller handshake bundle for conv1d_sequencer: phase busy flags in,
// resets and phase-start pulses out.
interface conv1d_sequencer_if;
    logic Weight_Loading_From_File;
    logic Output_Loading_From_File;
    logic Input_Loading_From_File;
    logic Computing;
    logic Output_Writing_To_File;

    logic Mem_Reset;
    logic Comp_Reset;
    logic Weight_Mem_Index_Reset;
    logic Output_Mem_Index_Reset;
    logic Input_Mem_Index_Reset;

    logic Weight_Loading_Signal;
    logic Output_Loading_Signal;
    logic Input_Loading_Signal;
    logic Computing_Signal;
    logic Output_Writing_Signal;

    modport master (
        input  Weight_Loading_From_File, Output_Loading_From_File, Input_Loading_From_File,
               Computing, Output_Writing_To_File,
        output Mem_Reset, Comp_Reset, Weight_Mem_Index_Reset, Output_Mem_Index_Reset,
               Input_Mem_Index_Reset, Weight_Loading_Signal, Output_Loading_Signal,
               Input_Loading_Signal, Computing_Signal, Output_Writing_Signal
    );

    modport slave (
        output Weight_Loading_From_File, Output_Loading_From_File, Input_Loading_From_File,
               Computing, Output_Writing_To_File,
        input  Mem_Reset, Comp_Reset, Weight_Mem_Index_Reset, Output_Mem_Index_Reset,
               Input_Mem_Index_Reset, Weight_Loading_Signal, Output_Loading_Signal,
               Input_Loading_Signal, Computing_Signal, Output_Writing_Signal
    );
endinterface

// File: rtl/conv1d_sequencer.sv
// Phase sequencer for a 1-D convolution run: clear, load weights/outputs/inputs,
// compute, write back. Define SEQ_TIMEOUT_EN to add the WAIT-state watchdog and ERROR state.
module conv1d_sequencer #(
    parameter int Clear_Cycles    = 2,
    parameter int Timeout_Cycles  = 64,
    parameter int Timeout_in_bits = 7,
    parameter bit Load_Output     = 1'b1
) (
    input  logic                clk,
    input  logic                Reset_n,
    input  logic                Start,
    conv1d_sequencer_if.master  mem,
    output logic                Busy,
    output logic                Done,
    output logic                Error,
    output logic [3:0]          State
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_CLEAR   = 4'd1,
        S_LOAD_W  = 4'd2,
        S_WAIT_W  = 4'd3,
        S_LOAD_O  = 4'd4,
        S_WAIT_O  = 4'd5,
        S_LOAD_I  = 4'd6,
        S_WAIT_I  = 4'd7,
        S_COMP    = 4'd8,
        S_WAIT_C  = 4'd9,
        S_WRITE   = 4'd10,
        S_WAIT_WR = 4'd11,
        S_DONE    = 4'd12,
        S_ERROR   = 4'd13
    } state_t;

    localparam int CLR_W = (Clear_Cycles > 1) ? $clog2(Clear_Cycles) : 1;
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(Clear_Cycles - 1);

    if (Clear_Cycles < 1 || Timeout_Cycles < 1 || Timeout_in_bits < 1 ||
        (Timeout_Cycles - 1) >= (1 << Timeout_in_bits)) begin : g_bad_params
        $error("conv1d_sequencer: illegal parameter combination");
    end

    state_t             state_q, state_d;
    logic [CLR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic               seen_q, seen_d;
    logic [4:0]         pulse_q, pulse_d;
    logic               clr_rst_q, clr_rst_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               in_wait;
    logic               wait_flag;
    logic               wait_done;

`ifdef SEQ_TIMEOUT_EN
    localparam logic [Timeout_in_bits-1:0] WD_LAST = Timeout_in_bits'(Timeout_Cycles - 1);
    logic [Timeout_in_bits-1:0] wd_q, wd_d;
    logic                       error_q, error_d;
`endif

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = '0;
        in_wait   = 1'b0;
        wait_flag = 1'b0;

        // Only the busy flag owned by the current WAIT state is looked at.
        case (state_q)
            S_WAIT_W:  begin in_wait = 1'b1; wait_flag = mem.Weight_Loading_From_File; end
            S_WAIT_O:  begin in_wait = 1'b1; wait_flag = mem.Output_Loading_From_File; end
            S_WAIT_I:  begin in_wait = 1'b1; wait_flag = mem.Input_Loading_From_File;  end
            S_WAIT_C:  begin in_wait = 1'b1; wait_flag = mem.Computing;                end
            S_WAIT_WR: begin in_wait = 1'b1; wait_flag = mem.Output_Writing_To_File;   end
            default:   ;
        endcase
        wait_done = in_wait && seen_q && !wait_flag;

        case (state_q)
            S_IDLE:    if (Start) state_d = S_CLEAR;
            S_CLEAR: begin
                if (clr_cnt_q == CLR_LAST) state_d = S_LOAD_W;
                else                       clr_cnt_d = clr_cnt_q + 1'b1;
            end
            S_LOAD_W:  state_d = S_WAIT_W;
            S_WAIT_W:  if (wait_done) state_d = Load_Output ? S_LOAD_O : S_LOAD_I;
            S_LOAD_O:  state_d = S_WAIT_O;
            S_WAIT_O:  if (wait_done) state_d = S_LOAD_I;
            S_LOAD_I:  state_d = S_WAIT_I;
            S_WAIT_I:  if (wait_done) state_d = S_COMP;
            S_COMP:    state_d = S_WAIT_C;
            S_WAIT_C:  if (wait_done) state_d = S_WRITE;
            S_WRITE:   state_d = S_WAIT_WR;
            S_WAIT_WR: if (wait_done) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            S_ERROR:   if (Start) state_d = S_CLEAR;
            default:   state_d = S_IDLE;
        endcase

`ifdef SEQ_TIMEOUT_EN
        wd_d = '0;
        if (in_wait && state_d == state_q) begin
            if (wd_q == WD_LAST) state_d = S_ERROR;
            else                 wd_d = wd_q + 1'b1;
        end
        error_d = (state_d == S_ERROR);
`endif

        // A flag that is low on entry must rise before its fall counts as completion.
        seen_d = in_wait && (state_d == state_q) && (seen_q || wait_flag);

        pulse_d[0] = (state_q == S_LOAD_W);
        pulse_d[1] = (state_q == S_LOAD_O);
        pulse_d[2] = (state_q == S_LOAD_I);
        pulse_d[3] = (state_q == S_COMP);
        pulse_d[4] = (state_q == S_WRITE);

        clr_rst_d = (state_d == S_CLEAR);
        busy_d    = (state_d != S_IDLE) && (state_d != S_ERROR);
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= S_IDLE;
            clr_cnt_q <= '0;
            seen_q    <= 1'b0;
            pulse_q   <= '0;
            clr_rst_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            seen_q    <= seen_d;
            pulse_q   <= pulse_d;
            clr_rst_q <= clr_rst_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wd_q    <= '0;
            error_q <= 1'b0;
        end else begin
            wd_q    <= wd_d;
            error_q <= error_d;
        end
    end
    assign Error = error_q;
`else
    assign Error = 1'b0;
`endif

    assign State = state_q;
    assign Busy  = busy_q;
    assign Done  = done_q;

    assign mem.Mem_Reset              = clr_rst_q;
    assign mem.Comp_Reset             = clr_rst_q;
    assign mem.Weight_Mem_Index_Reset = clr_rst_q;
    assign mem.Output_Mem_Index_Reset = clr_rst_q;
    assign mem.Input_Mem_Index_Reset  = clr_rst_q;

    assign mem.Weight_Loading_Signal  = pulse_q[0];
    assign mem.Output_Loading_Signal  = pulse_q[1];
    assign mem.Input_Loading_Signal   = pulse_q[2];
    assign mem.Computing_Signal       = pulse_q[3];
    assign mem.Output_Writing_Signal  = pulse_q[4];

endmodule

// File: tb/tb_conv1d_sequencer.sv
// Bench for conv1d_sequencer: a Load_Output=1 and a Load_Output=0 instance driven by a
// memory-controller model, with a pulse-order scoreboard and cycle-latency table.
module tb_conv1d_sequencer;

    logic clk;
    logic Reset_n;
    logic start [2];
    logic busy  [2];
    logic done  [2];
    logic error [2];
    logic [3:0] state [2];

    logic [4:0] pulse    [2];
    logic [4:0] rsts     [2];
    logic [4:0] flag_mdl [2];
    logic       man_en;
    logic       man_val;

    int total = 0;
    int bad   = 0;
    int dly   = 3;
    int hold  = 3;
    int tmr [2][5];
    int done_cnt [2];
    int bad_state1 = 0;
    int q0[$];
    int q1[$];

    typedef struct {
        int dly;
        int hold;
        int lat0;
        int lat1;
    } vec_t;
    vec_t vecs [6];

    conv1d_sequencer_if mif0();
    conv1d_sequencer_if mif1();

    conv1d_sequencer #(.Load_Output(1'b1)) dut0 (
        .clk(clk), .Reset_n(Reset_n), .Start(start[0]), .mem(mif0),
        .Busy(busy[0]), .Done(done[0]), .Error(error[0]), .State(state[0])
    );

    conv1d_sequencer #(.Load_Output(1'b0)) dut1 (
        .clk(clk), .Reset_n(Reset_n), .Start(start[1]), .mem(mif1),
        .Busy(busy[1]), .Done(done[1]), .Error(error[1]), .State(state[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign pulse[0] = {mif0.Output_Writing_Signal, mif0.Computing_Signal, mif0.Input_Loading_Signal,
                       mif0.Output_Loading_Signal, mif0.Weight_Loading_Signal};
    assign pulse[1] = {mif1.Output_Writing_Signal, mif1.Computing_Signal, mif1.Input_Loading_Signal,
                       mif1.Output_Loading_Signal, mif1.Weight_Loading_Signal};
    assign rsts[0]  = {mif0.Mem_Reset, mif0.Comp_Reset, mif0.Weight_Mem_Index_Reset,
                       mif0.Output_Mem_Index_Reset, mif0.Input_Mem_Index_Reset};
    assign rsts[1]  = {mif1.Mem_Reset, mif1.Comp_Reset, mif1.Weight_Mem_Index_Reset,
                       mif1.Output_Mem_Index_Reset, mif1.Input_Mem_Index_Reset};

    assign mif0.Weight_Loading_From_File = flag_mdl[0][0];
    assign mif0.Output_Loading_From_File = flag_mdl[0][1];
    assign mif0.Input_Loading_From_File  = flag_mdl[0][2];
    assign mif0.Computing                = man_en ? man_val : flag_mdl[0][3];
    assign mif0.Output_Writing_To_File   = flag_mdl[0][4];
    assign mif1.Weight_Loading_From_File = flag_mdl[1][0];
    assign mif1.Output_Loading_From_File = flag_mdl[1][1];
    assign mif1.Input_Loading_From_File  = flag_mdl[1][2];
    assign mif1.Computing                = flag_mdl[1][3];
    assign mif1.Output_Writing_To_File   = flag_mdl[1][4];

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic sb_pop(input int d, input int p);
        int e;
        e = -1;
        if (d == 0) begin
            if (q0.size() > 0) e = q0.pop_front();
        end else begin
            if (q1.size() > 0) e = q1.pop_front();
        end
        check($sformatf("pulse_order_dut%0d", d), p, e);
    endtask

    // Memory-controller model: flag rises dly cycles after a start pulse, stays high hold cycles.
    initial begin
        for (int d = 0; d < 2; d++) begin
            flag_mdl[d] = '0;
            for (int p = 0; p < 5; p++) tmr[d][p] = 0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < 5; p++) begin
                    if (!Reset_n)             tmr[d][p] = 0;
                    else if (pulse[d][p])     tmr[d][p] = dly + hold;
                    else if (tmr[d][p] > 0)   tmr[d][p] = tmr[d][p] - 1;
                    flag_mdl[d][p] = (tmr[d][p] > 0) && (tmr[d][p] <= hold);
                end
            end
        end
    end

    initial begin
        done_cnt[0] = 0;
        done_cnt[1] = 0;
        forever begin
            @(negedge clk);
            if (Reset_n) begin
                for (int p = 0; p < 5; p++) begin
                    if (pulse[0][p]) sb_pop(0, p);
                    if (pulse[1][p]) sb_pop(1, p);
                end
                if (done[0]) done_cnt[0]++;
                if (done[1]) done_cnt[1]++;
                if (state[1] == 4'd4 || state[1] == 4'd5) bad_state1++;
            end
        end
    end

    task automatic push_seq(input bit go0, input bit go1);
        if (go0) begin
            q0.push_back(0); q0.push_back(1); q0.push_back(2); q0.push_back(3); q0.push_back(4);
        end
        if (go1) begin
            q1.push_back(0); q1.push_back(2); q1.push_back(3); q1.push_back(4);
        end
    endtask

    // mode 0: plain run; 1: re-pulse Start during WAIT_I; 2: Computing high before WAIT_C entry.
    task automatic run(input bit go0, input bit go1, input int mode, output int l0, output int l1,
                       output int write_entries);
        int ph;
        bit inj;
        push_seq(go0, go1);
        start[0] = go0;
        start[1] = go1;
        l0 = -1; l1 = -1; ph = 0; inj = 1'b0; write_entries = 0;
        for (int n = 1; n <= 600; n++) begin
            @(negedge clk);
            start[0] = 1'b0;
            start[1] = 1'b0;
            if (mode == 1 && !inj && state[0] == 4'd7) begin
                start[0] = 1'b1;
                inj = 1'b1;
            end
            if (mode == 2) begin
                if (ph == 0 && state[0] == 4'd8) begin man_val = 1'b1; ph = 1; end
                else if (ph == 1) ph = 2;
                else if (ph == 2) begin man_val = 1'b0; ph = 3; end
            end
            if (state[0] == 4'd10) write_entries++;
            if (done[0] && l0 < 0) l0 = n;
            if (done[1] && l1 < 0) l1 = n;
            if ((l0 >= 0 || !go0) && (l1 >= 0 || !go1)) break;
        end
        if (go0 && l0 < 0) check("done0_within_budget", 0, 1);
        if (go1 && l1 < 0) check("done1_within_budget", 0, 1);
        @(negedge clk);
    endtask

    initial begin
        int l0, l1, wr, exp_done0, exp_done1, n;
        vecs[0] = '{3, 3, 43, 35};
        vecs[1] = '{1, 1, 23, 19};
        vecs[2] = '{0, 1, 18, 15};
        vecs[3] = '{5, 1, 43, 35};
        vecs[4] = '{2, 4, 43, 35};
        vecs[5] = '{0, 3, 28, 23};
        exp_done0 = 0;
        exp_done1 = 0;

        start[0] = 1'b0; start[1] = 1'b0;
        man_en = 1'b0; man_val = 1'b0;
        Reset_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset_state%0d", d), state[d], 0);
            check($sformatf("reset_resets%0d", d), rsts[d], 5'h1f);
            check($sformatf("reset_busy%0d", d), busy[d], 0);
            check($sformatf("reset_done%0d", d), done[d], 0);
            check($sformatf("reset_error%0d", d), error[d], 0);
            check($sformatf("reset_pulses%0d", d), pulse[d], 0);
        end
        Reset_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++)
            check($sformatf("resets_release%0d", d), rsts[d], 0);

        for (int i = 0; i < 6; i++) begin
            dly  = vecs[i].dly;
            hold = vecs[i].hold;
            run(1'b1, 1'b1, 0, l0, l1, wr);
            exp_done0++; exp_done1++;
            check($sformatf("latency0_v%0d", i), l0, vecs[i].lat0);
            check($sformatf("latency1_v%0d", i), l1, vecs[i].lat1);
            check($sformatf("idle0_v%0d", i), state[0], 0);
            check($sformatf("idle1_v%0d", i), state[1], 0);
            check($sformatf("busy_low_v%0d", i), busy[0] | busy[1], 0);
            check($sformatf("sb_empty_v%0d", i), q0.size() + q1.size(), 0);
        end

        dly = 2; hold = 2;
        run(1'b1, 1'b0, 1, l0, l1, wr);
        exp_done0++;
        check("start_in_wait_i_latency", l0, 33);
        check("start_in_wait_i_idle", state[0], 0);

        man_en = 1'b1; man_val = 1'b0;
        run(1'b1, 1'b0, 2, l0, l1, wr);
        exp_done0++;
        man_en = 1'b0;
        check("comp_high_on_entry_latency", l0, 30);
        check("comp_high_on_entry_write_once", wr, 1);

        push_seq(1'b1, 1'b0);
        start[0] = 1'b1;
        n = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            start[0] = 1'b0;
            if (state[0] == 4'd9) break;
            n++;
        end
        check("reached_wait_c", state[0], 9);
        #2 Reset_n = 1'b0;
        #1;
        check("abort_state", state[0], 0);
        check("abort_resets", rsts[0], 5'h1f);
        check("abort_busy", busy[0], 0);
        check("abort_done", done[0], 0);
        q0.delete();
        repeat (2) @(negedge clk);
        Reset_n = 1'b1;
        l0 = done_cnt[0];
        repeat (30) @(negedge clk);
        check("abort_no_done", done_cnt[0], l0);
        check("abort_idle", state[0], 0);

`ifdef SEQ_TIMEOUT_EN
        man_en = 1'b1; man_val = 1'b0;
        q0.push_back(0); q0.push_back(1); q0.push_back(2); q0.push_back(3);
        start[0] = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            start[0] = 1'b0;
            if (state[0] == 4'd9) break;
        end
        n = 0;
        for (int k = 0; k < 200; k++) begin
            if (state[0] != 4'd9) break;
            n++;
            @(negedge clk);
        end
        check("timeout_cycles", n, 64);
        check("timeout_state", state[0], 13);
        check("timeout_error", error[0], 1);
        check("timeout_busy", busy[0], 0);
        man_en = 1'b0;
        push_seq(1'b1, 1'b0);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        check("restart_state", state[0], 1);
        check("restart_error", error[0], 0);
        l0 = -1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (done[0]) begin l0 = k; break; end
        end
        exp_done0++;
        check("restart_done_seen", l0 >= 0, 1);
        @(negedge clk);
`endif

        check("done_count0", done_cnt[0], exp_done0);
        check("done_count1", done_cnt[1], exp_done1);
        check("no_output_phase_states", bad_state1, 0);
        check("sb_final_empty", q0.size() + q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
